// File: rtl/neuron_state_sequencer_pkg.sv
// Shared constants and FSM encoding for the neuron state sequencer.
package neuron_state_sequencer_pkg;

  localparam int WIDTH_DEF    = 32;
  localparam int FRAC_DEF     = 16;
  localparam int V_INIT_WHOLE = -65;  // resting potential in mV, scaled by FRAC at the top

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/neuron_state_sequencer_evt_fifo.sv
// Spike event FIFO: synchronous, power-of-2 depth, accepts a push on full when a pop happens the same cycle.
module spike_evt_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr, r_rd;
  logic         w_do_pop, w_do_push;

  // Extra pointer MSB distinguishes full from empty
  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr[AW-1:0]] <= i_data;
        r_wr <= r_wr + (AW+1)'(1);
      end
      if (w_do_pop) r_rd <= r_rd + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/neuron_state_sequencer.sv
// Time-multiplexes N_NEURONS Izhikevich neurons through one update pipe:
// issues operands, writes results back to state and queues spike events.
module neuron_state_sequencer
  import neuron_state_sequencer_pkg::*;
#(
  parameter int                       WIDTH     = WIDTH_DEF,
  parameter int                       FRAC      = FRAC_DEF,
  parameter int                       N_NEURONS = 16,
  parameter int                       IDX_W     = $clog2(N_NEURONS),
  parameter int                       PIPE_LAT  = 1,
  parameter int                       EVT_DEPTH = 4,
  parameter logic signed [WIDTH-1:0]  V_INIT    = WIDTH'(V_INIT_WHOLE) <<< FRAC
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              step_cnt,
  input  logic                     i_wr_en,
  input  logic [IDX_W-1:0]         i_wr_idx,
  input  logic signed [WIDTH-1:0]  i_wr_data,
  output logic                     pipe_en,
  output logic signed [WIDTH-1:0]  pipe_v,
  output logic signed [WIDTH-1:0]  pipe_u,
  output logic signed [WIDTH-1:0]  pipe_I,
  input  logic signed [WIDTH-1:0]  pipe_v_ret,
  input  logic signed [WIDTH-1:0]  pipe_u_ret,
  input  logic                     pipe_spike_ret,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [IDX_W-1:0]         evt_idx,
  output logic                     evt_overflow
);
  localparam logic signed [WIDTH-1:0] U_INIT = '0;

  seq_state_e                      r_state;
  logic [IDX_W-1:0]                r_idx;
  logic                            r_busy, r_done, r_pipe_en, r_evt_ovf;
  logic [15:0]                     r_step_cnt;
  logic signed [WIDTH-1:0]         r_v [N_NEURONS];
  logic signed [WIDTH-1:0]         r_u [N_NEURONS];
  logic signed [WIDTH-1:0]         r_I [N_NEURONS];
  logic [PIPE_LAT-1:0]             r_vld_pipe;
  logic [PIPE_LAT-1:0][IDX_W-1:0]  r_idx_pipe;

  logic             w_issue, w_ret_vld, w_push, w_pop, w_full, w_empty;
  logic [IDX_W-1:0] w_ret_idx;

  assign w_issue   = (r_state == ST_ISSUE);
  assign w_ret_vld = r_vld_pipe[PIPE_LAT-1];
  assign w_ret_idx = r_idx_pipe[PIPE_LAT-1];

  assign busy         = r_busy;
  assign done         = r_done;
  assign step_cnt     = r_step_cnt;
  assign pipe_en      = r_pipe_en;
  assign evt_overflow = r_evt_ovf;
  // Combinational read: a same-cycle I write lands after this issue sees the old value
  assign pipe_v       = w_issue ? r_v[r_idx] : '0;
  assign pipe_u       = w_issue ? r_u[r_idx] : '0;
  assign pipe_I       = w_issue ? r_I[r_idx] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pipe_en  <= 1'b0;
      r_step_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: if (start) begin
          r_state   <= ST_ISSUE;
          r_idx     <= '0;
          r_busy    <= 1'b1;
          r_pipe_en <= 1'b1;
        end
        ST_ISSUE: begin
          if (r_idx == IDX_W'(N_NEURONS-1)) r_state <= ST_DRAIN;
          else                              r_idx   <= r_idx + IDX_W'(1);
        end
        ST_DRAIN: if (r_vld_pipe == '0) begin
          r_state    <= ST_DONE;
          r_done     <= 1'b1;
          r_pipe_en  <= 1'b0;
          r_step_cnt <= r_step_cnt + 16'd1;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // In-flight tags, aligned with the pipe's result latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_idx_pipe <= '0;
    end else begin
      r_vld_pipe[0] <= w_issue;
      r_idx_pipe[0] <= r_idx;
      for (int s = 1; s < PIPE_LAT; s++) begin
        r_vld_pipe[s] <= r_vld_pipe[s-1];
        r_idx_pipe[s] <= r_idx_pipe[s-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_NEURONS; k++) begin
        r_v[k] <= V_INIT;
        r_u[k] <= U_INIT;
      end
    end else if (w_ret_vld) begin
      r_v[w_ret_idx] <= pipe_v_ret;
      r_u[w_ret_idx] <= pipe_u_ret;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_NEURONS; k++) r_I[k] <= '0;
    end else if (i_wr_en) begin
      r_I[i_wr_idx] <= i_wr_data;
    end
  end

  assign w_push    = w_ret_vld && pipe_spike_ret;
  assign w_pop     = evt_valid && evt_ready;
  assign evt_valid = !w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_evt_ovf <= 1'b0;
    else if (w_push && w_full && !w_pop) r_evt_ovf <= 1'b1;
  end

  spike_evt_fifo #(.W(IDX_W), .DEPTH(EVT_DEPTH)) u_evt_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_ret_idx),
    .i_pop   (w_pop),
    .o_data  (evt_idx),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
endmodule
